gpio_bus_arbiter: RTL and testbench
===================================

Name: gpio_bus_arbiter

Overview:
- Shares the single GPIO register write/read port (addr[3:0], wdata[7:0], we, rdata[7:0]) between N_REQ requesters, e.g. CPU core, debug/UART loader and PWM duty sequencer.
- Round-robin arbitration with optional bus lock for multi-register updates, and a lock timeout so one requester cannot starve the others.
- Sits between the requesters and the GPIO register instance in the top level; the GPIO register sees a single master.

Parameters:
- N_REQ, 3, number of requesters (2..4).
- MAX_LOCK, 4, max consecutive locked transactions one requester may hold before forced rotation (1..15).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-low reset (sampled on rising clk; 0 = reset).
- req  in  N_REQ  per-requester transaction request.
- req_lock  in  N_REQ  per-requester lock request; keep grant after current transaction.
- req_we  in  N_REQ  per-requester write enable (1 = write, 0 = read).
- req_addr  in  4*N_REQ  packed addresses, requester i at [4i+3:4i].
- req_wdata  in  8*N_REQ  packed write data, requester i at [8i+7:8i].
- ack  out  N_REQ  one-hot, one-cycle transaction-complete pulse.
- rdata  out  8  read data, valid in the cycle ack is high; holds value otherwise.
- owner  out  2  index of the last/current granted requester.
- bus_addr  out  4  to GPIO register addr.
- bus_wdata  out  8  to GPIO register wdata.
- bus_we  out  1  to GPIO register we; single-cycle pulse.
- bus_rdata  in  8  from GPIO register rdata_out.

Behaviour:
- Reset (rst=0 at rising edge):
  - state=IDLE; ack=0, bus_we=0, bus_addr=0, bus_wdata=0, rdata=0.
  - owner=N_REQ-1, so requester 0 has first priority.
  - lock_cnt=0.
  - Reset mid-transaction aborts it: no ack, and bus_we drops the next cycle.
- FSM states: IDLE, ACCESS, ACK.
- IDLE:
  - If any req bit is set, select winner w = first set bit searching owner+1, owner+2, ... (mod N_REQ). Lock-hold overrides this (see below).
  - Capture req_addr/req_wdata/req_we of w into bus_addr/bus_wdata/bus_we; owner<=w; go to ACCESS.
  - If no req, stay in IDLE with bus_we=0.
- ACCESS (exactly 1 cycle):
  - bus_* stable and bus_we = captured we.
  - The GPIO register performs the write on this edge.
  - Go to ACK.
- ACK (exactly 1 cycle):
  - ack[owner]=1; rdata<=bus_rdata, sampled on the ACCESS->ACK edge so it is valid in the ACK cycle.
  - bus_we=0; go to IDLE.
- Latency: req seen in IDLE at cycle T -> bus_we at T+1 -> ack at T+2.
- Throughput: max 1 transaction per 3 cycles.
- Requester handshake:
  - Inputs are sampled only on the IDLE->ACCESS edge; later changes do not affect the in-flight transaction.
  - Dropping req during ACCESS/ACK does not cancel it; ack still pulses.
  - Requester must drop req in the cycle after ack, else its req is treated as a new request.
- Lock:
  - If in ACK req_lock[owner]=1 and lock_cnt < MAX_LOCK-1: lock_cnt++ and mark hold.
  - If in the next IDLE req[owner]=1, owner wins regardless of round-robin.
  - Otherwise lock_cnt<=0 and normal rotation applies.
  - When lock_cnt reaches MAX_LOCK-1, hold is released even if req_lock stays high. The next arbitration starts from owner+1; the lock holder may win again only if no other req is set.
  - If hold is set but req[owner]=0 in IDLE, the lock is released (lock_cnt=0) and round-robin applies that cycle.
- Simultaneous requests: only round-robin order matters; no fixed priority beyond reset start point.
- Read transactions (req_we=0) never assert bus_we; bus_addr is still driven so rdata reflects bus_rdata of that address.
- owner is undefined-free: always a valid index 0..N_REQ-1.

Test Plan:
- Reset: rst=0 two cycles -> ack=0, bus_we=0, rdata=0, owner=2. Then req=3'b001, addr=4'h2, wdata=8'hA5, we=1 -> bus_we=1, bus_addr=2, bus_wdata=A5 one cycle later; ack=3'b001 the cycle after.
- Fairness: req=3'b111 held continuously (re-asserted after each ack) -> grant order 0,1,2,0,1,2 over 6 transactions. ack never two bits high; 18 cycles total.
- Lock: req=3'b011, req_lock[1]=1, MAX_LOCK=4, starting owner=0 -> requester 1 gets 4 consecutive acks, then requester 0. Next arbitration goes to 0 even though req_lock[1] is still high.
- Read: requester 2 read addr 4'h5 with bus_rdata model returning 8'h3C -> bus_we stays 0; ack[2]=1 with rdata=8'h3C.
- Input change in flight: requester 0 write wdata=8'h11, change req_wdata to 8'hFF during ACCESS -> bus_wdata stays 8'h11; ack still pulses.
- Reset mid-operation: assert rst=0 in the ACCESS cycle -> next cycle bus_we=0, no ack, state IDLE, owner=2.

Source files
------------

// File: rtl/gpio_bus_arbiter_if.sv
// Requester-side handshake and GPIO register port of the bus arbiter.
// master: the requester/GPIO-register side; slave: the arbiter itself.
interface gpio_bus_arbiter_if #(
   parameter int unsigned N_REQ = 3
);
   logic [N_REQ-1:0]   req;
   logic [N_REQ-1:0]   req_lock;
   logic [N_REQ-1:0]   req_we;
   logic [4*N_REQ-1:0] req_addr;
   logic [8*N_REQ-1:0] req_wdata;
   logic [N_REQ-1:0]   ack;
   logic [7:0]         rdata;
   logic [1:0]         owner;
   logic [3:0]         bus_addr;
   logic [7:0]         bus_wdata;
   logic               bus_we;
   logic [7:0]         bus_rdata;

   modport master (
      output req, req_lock, req_we, req_addr, req_wdata, bus_rdata,
      input  ack, rdata, owner, bus_addr, bus_wdata, bus_we
   );

   modport slave (
      input  req, req_lock, req_we, req_addr, req_wdata, bus_rdata,
      output ack, rdata, owner, bus_addr, bus_wdata, bus_we
   );
endinterface

// File: rtl/gpio_bus_arbiter.sv
// Round-robin arbiter sharing one GPIO register port between N_REQ requesters.
// Each transaction takes IDLE -> ACCESS -> ACK; a requester may lock the bus
// for up to MAX_LOCK consecutive transactions.
module gpio_bus_arbiter #(
   parameter int unsigned N_REQ    = 3,
   parameter int unsigned MAX_LOCK = 4
) (
   input logic              clk,
   input logic              rst,
   gpio_bus_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      ACK
   } state_t;

   localparam logic [3:0] LOCK_LIMIT = 4'(MAX_LOCK - 1);
   localparam logic [1:0] LAST_REQ   = 2'(N_REQ - 1);

   state_t           state_q, state_d;
   logic [1:0]       owner_q, owner_d;
   logic [3:0]       lock_cnt_q, lock_cnt_d;
   logic             hold_q, hold_d;
   logic [3:0]       addr_q, addr_d;
   logic [7:0]       wdata_q, wdata_d;
   logic             we_q, we_d;
   logic [N_REQ-1:0] ack_q, ack_d;
   logic [7:0]       rdata_q, rdata_d;

   logic [1:0]       rr_winner;
   logic             rr_found;

   // Round-robin search: first requester after the current owner, wrapping.
   always_comb begin
      logic [1:0] cand;
      cand      = '0;
      rr_winner = owner_q;
      rr_found  = 1'b0;
      for (int unsigned k = 1; k <= N_REQ; k++) begin
         cand = 2'((32'(owner_q) + k) % N_REQ);
         if (!rr_found && bus.req[cand]) begin
            rr_winner = cand;
            rr_found  = 1'b1;
         end
      end
   end

   // Next-state and datapath: grant, bus access, ack and lock bookkeeping.
   always_comb begin
      logic       grant;
      logic [1:0] win;
      state_d    = state_q;
      owner_d    = owner_q;
      lock_cnt_d = lock_cnt_q;
      hold_d     = hold_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      we_d       = 1'b0;
      ack_d      = '0;
      rdata_d    = rdata_q;
      grant      = 1'b0;
      win        = owner_q;

      unique case (state_q)
         IDLE: begin
            if (hold_q && bus.req[owner_q]) begin
               grant = 1'b1;
               win   = owner_q;
            end else begin
               // A hold whose owner is not requesting is dropped and
               // round-robin decides this very cycle.
               if (hold_q) begin
                  hold_d     = 1'b0;
                  lock_cnt_d = '0;
               end
               grant = rr_found;
               win   = rr_winner;
            end
            if (grant) begin
               owner_d = win;
               addr_d  = bus.req_addr[4*win +: 4];
               wdata_d = bus.req_wdata[8*win +: 8];
               we_d    = bus.req_we[win];
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            ack_d[owner_q] = 1'b1;
            rdata_d        = bus.bus_rdata;
            state_d        = ACK;
         end
         ACK: begin
            if (bus.req_lock[owner_q] && (lock_cnt_q < LOCK_LIMIT)) begin
               lock_cnt_d = lock_cnt_q + 4'd1;
               hold_d     = 1'b1;
            end else begin
               lock_cnt_d = '0;
               hold_d     = 1'b0;
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         owner_q    <= LAST_REQ;
         lock_cnt_q <= '0;
         hold_q     <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         we_q       <= 1'b0;
         ack_q      <= '0;
         rdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         lock_cnt_q <= lock_cnt_d;
         hold_q     <= hold_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         we_q       <= we_d;
         ack_q      <= ack_d;
         rdata_q    <= rdata_d;
      end
   end

   assign bus.ack       = ack_q;
   assign bus.rdata     = rdata_q;
   assign bus.owner     = owner_q;
   assign bus.bus_addr  = addr_q;
   assign bus.bus_wdata = wdata_q;
   assign bus.bus_we    = we_q;

endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// Self-checking bench for gpio_bus_arbiter: directed scenarios followed by
// random transactions, checked against a transaction-level arbitration model.
module tb_gpio_bus_arbiter;

   localparam int N  = 3;
   localparam int ML = 4;

   logic clk;
   logic rst;
   logic model_clear;

   int n_vec;
   int n_err;

   // Transaction-level reference state.
   int         m_owner;
   bit         m_hold;
   int         m_run;
   logic [7:0] ref_mem [16];

   gpio_bus_arbiter_if #(.N_REQ(N)) bif ();

   gpio_bus_arbiter #(
      .N_REQ    (N),
      .MAX_LOCK (ML)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif.slave)
   );

   // Behavioural GPIO register file behind the arbiter.
   logic [7:0] gmem [16];
   always @(posedge clk) begin
      if (model_clear) begin
         for (int i = 0; i < 16; i++) gmem[i] <= 8'h00;
      end else if (bif.bus_we) begin
         gmem[bif.bus_addr] <= bif.bus_wdata;
      end
   end
   assign bif.bus_rdata = gmem[bif.bus_addr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      assert (got === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_owner = N - 1;
      m_hold  = 0;
      m_run   = 0;
   endtask

   task automatic do_reset();
      rst           = 1'b0;
      bif.req       = '0;
      bif.req_lock  = '0;
      bif.req_we    = '0;
      bif.req_addr  = '0;
      bif.req_wdata = '0;
      model_reset();
      step();
      step();
      chk("rst_ack", bif.ack, 0);
      chk("rst_we", bif.bus_we, 0);
      chk("rst_owner", bif.owner, N - 1);
      rst = 1'b1;
   endtask

   // One arbitration slot: drive inputs in IDLE, then follow ACCESS and ACK.
   task automatic txn(input logic [2:0] r, input logic [2:0] lk, input logic [2:0] we,
                      input logic [11:0] a, input logic [23:0] d);
      int         w;
      int         c;
      logic [3:0] wa;
      logic [7:0] exp_rd;
      bif.req       = r;
      bif.req_lock  = lk;
      bif.req_we    = we;
      bif.req_addr  = a;
      bif.req_wdata = d;
      if (r == 3'b000) begin
         m_hold = 0;
         step();
         chk("idle_we", bif.bus_we, 0);
         chk("idle_ack", bif.ack, 0);
         chk("idle_owner", bif.owner, m_owner);
         return;
      end
      w = -1;
      if (m_hold && r[m_owner]) begin
         w = m_owner;
         m_run++;
      end else begin
         for (int k = 1; k <= N; k++) begin
            c = (m_owner + k) % N;
            if (w < 0 && r[c]) w = c;
         end
         m_run = 1;
      end
      m_hold  = 0;
      m_owner = w;
      wa      = a[4*w +: 4];
      step();
      chk("acc_owner", bif.owner, w);
      chk("acc_we", bif.bus_we, we[w]);
      chk("acc_addr", bif.bus_addr, wa);
      chk("acc_wdata", bif.bus_wdata, d[8*w +: 8]);
      chk("acc_ack", bif.ack, 0);
      bif.req_wdata = '1;
      bif.req_addr  = ~a;
      bif.req_we    = ~we;
      exp_rd = ref_mem[wa];
      if (we[w]) ref_mem[wa] = d[8*w +: 8];
      step();
      chk("ack", bif.ack, 1 << w);
      chk("ack_rdata", bif.rdata, exp_rd);
      chk("ack_we", bif.bus_we, 0);
      m_hold = lk[w] && (m_run < ML);
      step();
      chk("post_ack", bif.ack, 0);
   endtask

   initial begin
      int         fair_order [6];
      int         lock_order [6];
      logic [2:0] rr, rl, rw;
      fair_order = '{0, 1, 2, 0, 1, 2};
      lock_order = '{1, 1, 1, 1, 0, 1};
      n_vec = 0;
      n_err = 0;
      for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
      model_clear = 1'b1;
      do_reset();
      chk("rst_rdata", bif.rdata, 0);
      chk("rst_addr", bif.bus_addr, 0);
      chk("rst_wdata", bif.bus_wdata, 0);
      model_clear = 1'b0;

      // First write from requester 0 straight out of reset.
      txn(3'b001, 3'b000, 3'b001, 12'h002, 24'h0000A5);
      chk("first_owner", bif.owner, 0);
      chk("first_addr", bif.bus_addr, 4'h2);
      chk("first_wdata", bif.bus_wdata, 8'hA5);

      // Fairness: all three requesting continuously.
      do_reset();
      for (int i = 0; i < 6; i++) begin
         txn(3'b111, 3'b000, 3'b000, 12'h123, 24'h332211);
         chk("fair_order", bif.owner, fair_order[i]);
      end

      // Seed address 5 with 3C, leaving owner at 0.
      txn(3'b001, 3'b000, 3'b001, 12'h005, 24'h00003C);
      chk("seed_owner", bif.owner, 0);

      // Lock: requester 1 holds for MAX_LOCK transactions, then rotation.
      for (int i = 0; i < 6; i++) begin
         txn(3'b011, 3'b010, 3'b011, 12'h098, 24'h00B0A0 + 24'(i));
         chk("lock_order", bif.owner, lock_order[i]);
      end

      // Read by requester 2 of address 5.
      txn(3'b100, 3'b000, 3'b000, 12'h500, 24'h000000);
      chk("read_rdata", bif.rdata, 8'h3C);
      chk("read_owner", bif.owner, 2);

      // Input change while in flight: wdata is forced to FF during ACCESS.
      txn(3'b001, 3'b000, 3'b001, 12'h003, 24'h000011);
      chk("flight_wdata", bif.bus_wdata, 8'h11);

      // Reset in the ACCESS cycle aborts the transaction.
      bif.req       = 3'b001;
      bif.req_lock  = 3'b000;
      bif.req_we    = 3'b001;
      bif.req_addr  = 12'h007;
      bif.req_wdata = 24'h00005A;
      step();
      chk("mid_acc_we", bif.bus_we, 1);
      rst = 1'b0;
      bif.req = 3'b000;
      step();
      ref_mem[7] = 8'h5A;
      chk("mid_we", bif.bus_we, 0);
      chk("mid_ack", bif.ack, 0);
      chk("mid_owner", bif.owner, 2);
      rst = 1'b1;
      model_reset();
      step();
      chk("mid_post_ack", bif.ack, 0);
      chk("mid_post_we", bif.bus_we, 0);
      txn(3'b001, 3'b000, 3'b000, 12'h007, 24'h000000);
      chk("mid_readback", bif.rdata, 8'h5A);

      // Random transactions against the reference model.
      for (int i = 0; i < 300; i++) begin
         rr = 3'($urandom_range(0, 7));
         rl = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 2) == 0) rl = 3'b111;
         rw = 3'($urandom_range(0, 7));
         txn(rr, rl, rw, 12'($urandom), 24'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
